// File: rtl/stream_fifo_sync.sv
// Single-clock valid/ready stream FIFO with fill level and synchronous flush.
// Optional combinational bypass when empty: define STREAM_FIFO_SYNC_FALL_THROUGH_EN.
`timescale 1ns/1ps
module stream_fifo_sync #(
  parameter type         T         = logic,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  T                   data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output T                   data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [LOG_DEPTH:0] usage_o
);

  localparam int unsigned        DEPTH   = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] PTR_ONE = 1;

  logic [LOG_DEPTH:0]   r_wptr;
  logic [LOG_DEPTH:0]   r_rptr;
  T                     r_mem [DEPTH];

  logic [LOG_DEPTH-1:0] w_widx;
  logic [LOG_DEPTH-1:0] w_ridx;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_pop;

  assign w_widx  = r_wptr[LOG_DEPTH-1:0];
  assign w_ridx  = r_rptr[LOG_DEPTH-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[LOG_DEPTH] != r_rptr[LOG_DEPTH]) && (w_widx == w_ridx);
  assign usage_o = r_wptr - r_rptr;

  // Ready never looks at ready_i, so a pop cannot open a slot for a push in the same cycle.
  assign ready_o = !w_full && !flush_i;

`ifdef STREAM_FIFO_SYNC_FALL_THROUGH_EN
  assign w_bypass = w_empty && !flush_i && valid_i && ready_i;
  assign valid_o  = !flush_i && (!w_empty || valid_i);
  assign data_o   = w_empty ? data_i : r_mem[w_ridx];
`else
  assign w_bypass = 1'b0;
  assign valid_o  = !w_empty && !flush_i;
  assign data_o   = r_mem[w_ridx];
`endif

  // A bypassed element never touches storage, so neither pointer moves.
  assign w_push = valid_i && ready_o && !w_bypass;
  assign w_pop  = valid_o && ready_i && !w_bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[w_widx] <= data_i;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (flush_i) begin
        r_rptr <= r_wptr;
      end else if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // Upstream must hold an offered element, unchanged, until it is accepted.
  a_upstream_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (valid_i && !ready_o) |=> (valid_i && $stable(data_i))
  );

endmodule

// File: tb/tb_stream_fifo_sync.sv
// Randomized scoreboard bench for stream_fifo_sync (LOG_DEPTH = 3, 32-bit elements).
`timescale 1ns/1ps
module tb_stream_fifo_sync;

  localparam int unsigned LOG_DEPTH = 3;
  localparam int unsigned DEPTH     = 2 ** LOG_DEPTH;
`ifdef STREAM_FIFO_SYNC_FALL_THROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic [31:0]        data_i;
  logic               valid_i;
  logic               ready_o;
  logic [31:0]        data_o;
  logic               valid_o;
  logic               ready_i;
  logic [LOG_DEPTH:0] usage_o;

  stream_fifo_sync #(
    .T         (logic [31:0]),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .usage_o (usage_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: an ideal bounded queue of accepted elements.
  logic [31:0] mq [$];
  bit          acc_flag;
  bit          m_ready;
  bit          m_valid;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_usage", {28'b0, usage_o}, 32'd0);
      check("rst_ready", {31'b0, ready_o}, 32'd1);
      mq.delete();
      acc_flag = 1'b0;
    end else begin
      m_ready = (mq.size() < DEPTH) && !flush_i;
      m_valid = !flush_i && ((mq.size() != 0) || (FT && valid_i));
      check("ready_o", {31'b0, ready_o}, {31'b0, m_ready});
      check("valid_o", {31'b0, valid_o}, {31'b0, m_valid});
      check("usage_o", {28'b0, usage_o}, 32'(mq.size()));
      acc_flag = valid_i && m_ready;
      if (acc_flag) mq.push_back(data_i);
      if (m_valid) begin
        check("data_o", data_o, mq[0]);
        if (ready_i) void'(mq.pop_front());
      end
      if (flush_i) mq.delete();
    end
  end

  // Producer/consumer stimulus: each offered value is held until the model accepts it.
  int unsigned to_send  = 0;
  logic [31:0] next_val = '0;

  task automatic run(input int unsigned n, input int unsigned pv,
                     input int unsigned pr, input int unsigned pf);
    for (int unsigned i = 0; i < n; i++) begin
      if (!valid_i && to_send != 0 && $urandom_range(99) < pv) begin
        valid_i  = 1'b1;
        data_i   = next_val;
        next_val = next_val + 32'd1;
        to_send--;
      end
      ready_i = ($urandom_range(99) < pr);
      flush_i = ($urandom_range(999) < pf);
      @(posedge clk_i); #1;
      if (valid_i && acc_flag) valid_i = 1'b0;
    end
    flush_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int unsigned b = 0;
    while ((to_send != 0 || valid_i || mq.size() != 0) && b < 2000) begin
      run(1, 100, 100, 0);
      b++;
    end
    check(nm, 32'(mq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'd99;
    ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    rst_ni  = 1'b1;
    run(2, 0, 0, 0);
    check("post_rst_usage", {28'b0, usage_o}, 32'd0);

    // Fill with consumer stalled: 8 accepted, 8 and 9 held upstream.
    to_send = 10;
    run(14, 100, 0, 0);
    check("fill_usage", {28'b0, usage_o}, 32'd8);
    check("fill_ready", {31'b0, ready_o}, 32'd0);
    drain("fill_drain");

    // Steady state at occupancy 4.
    to_send = 4;
    run(6, 100, 0, 0);
    check("steady_pre", {28'b0, usage_o}, 32'd4);
    to_send = 20;
    run(20, 100, 100, 0);
    check("steady_post", {28'b0, usage_o}, 32'd4);
    drain("steady_drain");

    // Flush at occupancy 5, then 42 passes through normally.
    to_send = 5;
    run(7, 100, 0, 0);
    check("flush_pre", {28'b0, usage_o}, 32'd5);
    flush_i = 1'b1;
    #1;
    check("flush_ready", {31'b0, ready_o}, 32'd0);
    check("flush_valid", {31'b0, valid_o}, 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    #1;
    check("flush_usage", {28'b0, usage_o}, 32'd0);
    check("flush_valid_after", {31'b0, valid_o}, 32'd0);
    next_val = 32'd42;
    to_send  = 1;
    run(1, 100, 0, 0);
    check("flush_42", data_o, 32'd42);
    drain("flush_drain");

    // Latency from empty with consumer ready.
    valid_i = 1'b1;
    data_i  = 32'd7;
    ready_i = 1'b1;
    #1;
    check("ft_valid_now", {31'b0, valid_o}, {31'b0, FT});
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
`ifdef STREAM_FIFO_SYNC_FALL_THROUGH_EN
    check("ft_usage", {28'b0, usage_o}, 32'd0);
`else
    check("lat_valid", {31'b0, valid_o}, 32'd1);
    check("lat_data", data_o, 32'd7);
    check("lat_usage", {28'b0, usage_o}, 32'd1);
`endif
    drain("lat_drain");

    // Random stress with occasional flushes.
    to_send = 3000;
    b = 0;
    while ((to_send != 0 || valid_i) && b < 40000) begin
      run(1, 60, 50, 5);
      b++;
    end
    check("stress_sent", to_send, 32'd0);
    drain("stress_drain");

    // Asynchronous reset while loaded.
    to_send = 3;
    run(5, 100, 0, 0);
    check("arst_pre", {28'b0, usage_o}, 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", {31'b0, valid_o}, 32'd0);
    check("arst_usage", {28'b0, usage_o}, 32'd0);
`ifndef STREAM_FIFO_SYNC_FALL_THROUGH_EN
    check("arst_data", data_o, 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    run(2, 0, 100, 0);
    check("arst_post", {28'b0, usage_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
